uart_rx_core: RTL and testbench

//  Core-side 8N1 UART receiver with a small show-ahead receive FIFO.
//  It deserialises the byte stream that the host-side I/O model drives

---
 rtl/uart_rx_core.sv | 114 +++++++++++
 tb/tb_uart_rx_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 2-flop input synchroniser and show-ahead receive FIFO
module uart_rx_core #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rxd,
  output logic [7:0]         rdata,
  output logic               rvalid,
  input  logic               rready,
  output logic               frame_err,
  output logic               overrun,
  output logic [FIFO_AW:0]   count
);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_PER_HALF_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic s1_q, s1_d, rxs_q, rxs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic good, pop, push, full;
  always_comb begin
    s1_d = rxd;
    rxs_d = s1_q;
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    sh_d = sh_q;
    good = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rxs_q ? IDLE : START;
      end
      START: if (cnt_q == HALF_END) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rxs_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == BIT_END) begin
        cnt_d = '0;
        sh_d = {rxs_q, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == BIT_END) begin
        cnt_d = '0;
        good = rxs_q;
        frame_err_d = !rxs_q;
        state_d = rxs_q ? IDLE : BRK;
      end
      BRK: begin
        cnt_d = '0;
        state_d = rxs_q ? IDLE : BRK;
      end
      default: begin
        cnt_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  assign count = wr_q - rd_q;
  assign rvalid = count != '0;
  assign rdata = mem_q[rd_q[FIFO_AW-1:0]];
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
  always_comb begin
    full = count == (FIFO_AW+1)'(DEPTH);
    pop = rvalid && rready;
    push = good && (!full || pop);
    overrun_d = good && full && !pop;
    wr_d = wr_q + (FIFO_AW+1)'(push);
    rd_d = rd_q + (FIFO_AW+1)'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q[FIFO_AW-1:0]] = sh_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b1;
      rxs_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      rxs_q <= rxs_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench driving serial frames against a byte-queue reference model
module tb_uart_rx_core;
  localparam int H = 16;
  localparam int AW = 2;
  localparam int FR = 20 * H;
  logic clk = 0, rstn = 0, rxd = 1;
  logic rr_rand = 0, rr_rnd = 0, rr_hold = 0, rr_pulse = 0;
  logic rready;
  logic [7:0] rdata;
  logic rvalid, frame_err, overrun;
  logic [AW:0] count;
  int checks = 0, errors = 0;
  int fe_n = 0, ov_n = 0, rv_n = 0, gt1_n = 0;
  logic [7:0] got [$];
  bit rv_tr [FR];
  bit fe_tr [FR];
  bit ov_tr [FR];
  assign rready = rr_rand ? rr_rnd : (rr_hold | rr_pulse);
  always #5 clk = ~clk;
  uart_rx_core #(.CLK_PER_HALF_BIT(H), .FIFO_AW(AW)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .frame_err(frame_err), .overrun(overrun), .count(count)
  );
  always @(negedge clk) rr_rnd = 1'($urandom_range(1, 0));
  always @(negedge clk) begin
    #1;
    if (rstn) begin
      if (rvalid && rready) got.push_back(rdata);
      fe_n += int'(frame_err);
      ov_n += int'(overrun);
      rv_n += int'(rvalid);
      gt1_n += int'(count > 1);
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop, input int rr_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      rv_tr[k] = rvalid;
      fe_tr[k] = frame_err;
      ov_tr[k] = overrun;
      rr_pulse = (k == rr_at);
      rxd = bits[k / (2 * H)];
    end
    rr_pulse = 0;
  endtask
  task automatic drain();
    rr_hold = 1;
    for (int i = 0; i < 64 && count != 0; i++) @(negedge clk);
    rr_hold = 0;
    @(negedge clk);
    checks++;
    if (count !== 0) begin errors++; $display("FAIL drain count=%0d expected 0", count); end
  endtask
  task automatic test_reset();
    rstn = 0;
    rxd = 1;
    idle(3);
    checks += 5;
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    if (count !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    rstn = 1;
    idle(2);
  endtask
  task automatic test_single();
    int g0 = got.size();
    send_frame(8'h55, 1, -1);
    checks += 6;
    if (rv_tr[19*H+2] !== 1'b0) begin errors++; $display("FAIL single_early_rvalid got 1 exp 0"); end
    if (rv_tr[19*H+3] !== 1'b1) begin errors++; $display("FAIL single_rvalid_t19h1 got 0 exp 1"); end
    if (fe_tr[19*H+3] !== 1'b0) begin errors++; $display("FAIL single_frame_err got 1 exp 0"); end
    if (rdata !== 8'h55) begin errors++; $display("FAIL single_rdata got %h exp 55", rdata); end
    if (count !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    drain();
    if (got[g0] !== 8'h55) begin errors++; $display("FAIL single_pop got %h exp 55", got[g0]); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] exp [3] = '{8'h00, 8'hFF, 8'hA5};
    int g0 = got.size(), r0 = rv_n, c0 = gt1_n;
    rr_hold = 1;
    foreach (exp[i]) send_frame(exp[i], 1, -1);
    idle(4 * H);
    rr_hold = 0;
    checks += 3;
    if (got.size() - g0 !== 3) begin errors++; $display("FAIL b2b_pops got %0d exp 3", got.size() - g0); end
    if (rv_n - r0 !== 3) begin errors++; $display("FAIL b2b_rvalid_cycles got %0d exp 3", rv_n - r0); end
    if (gt1_n - c0 !== 0) begin errors++; $display("FAIL b2b_count_above_1 got %0d cycles exp 0", gt1_n - c0); end
    foreach (exp[i]) begin
      checks++;
      if (got[g0+i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, got[g0+i], exp[i]); end
    end
  endtask
  task automatic test_overrun();
    int g0 = got.size(), o0 = ov_n;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, -1);
    checks += 4;
    if (ov_tr[19*H+3] !== 1'b1) begin errors++; $display("FAIL ovr_pulse_time got 0 exp 1"); end
    if (ov_n - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ov_n - o0); end
    if (count !== 4) begin errors++; $display("FAIL ovr_count got %0d exp 4", count); end
    if (rdata !== 8'h01) begin errors++; $display("FAIL ovr_head got %h exp 01", rdata); end
    drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[g0+i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_drain%0d got %h exp %h", i, got[g0+i], 8'(i + 1)); end
    end
  endtask
  task automatic test_break();
    int g0 = got.size(), f0 = fe_n;
    send_frame(8'h3C, 0, -1);
    checks += 2;
    if (fe_tr[19*H+3] !== 1'b1) begin errors++; $display("FAIL brk_fe_time got 0 exp 1"); end
    if (count !== 0) begin errors++; $display("FAIL brk_no_push got %0d exp 0", count); end
    idle(30 * H);
    rxd = 1;
    idle(4 * H);
    checks += 2;
    if (count !== 0) begin errors++; $display("FAIL brk_spurious got %0d exp 0", count); end
    if (fe_n - f0 !== 1) begin errors++; $display("FAIL brk_fe_pulses got %0d exp 1", fe_n - f0); end
    send_frame(8'h7E, 1, -1);
    idle(2);
    checks += 2;
    if (count !== 1) begin errors++; $display("FAIL brk_next_count got %0d exp 1", count); end
    if (rdata !== 8'h7E) begin errors++; $display("FAIL brk_next_rdata got %h exp 7e", rdata); end
    drain();
    checks++;
    if (got.size() - g0 !== 1) begin errors++; $display("FAIL brk_pops got %0d exp 1", got.size() - g0); end
  endtask
  task automatic test_glitch();
    int f0 = fe_n, o0 = ov_n, r0 = rv_n;
    rxd = 0;
    idle(H / 2);
    rxd = 1;
    idle(22 * H);
    checks += 3;
    if (rv_n - r0 !== 0) begin errors++; $display("FAIL glitch_push got %0d valid cycles exp 0", rv_n - r0); end
    if (fe_n - f0 !== 0) begin errors++; $display("FAIL glitch_fe got %0d exp 0", fe_n - f0); end
    if (ov_n - o0 !== 0) begin errors++; $display("FAIL glitch_ovr got %0d exp 0", ov_n - o0); end
  endtask
  task automatic test_reset_mid();
    logic [9:0] bits = {1'b1, 8'h99, 1'b0};
    int g0 = got.size(), f0 = fe_n;
    for (int k = 0; k < 11 * H; k++) begin
      @(negedge clk);
      rxd = bits[k / (2 * H)];
    end
    rstn = 0;
    idle(3);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %b exp 0", rvalid); end
    rxd = 1;
    rstn = 1;
    idle(4 * H);
    send_frame(8'h42, 1, -1);
    idle(2);
    checks += 3;
    if (count !== 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", count); end
    if (rdata !== 8'h42) begin errors++; $display("FAIL rstmid_rdata got %h exp 42", rdata); end
    if (fe_n - f0 !== 0) begin errors++; $display("FAIL rstmid_fe got %0d exp 0", fe_n - f0); end
    drain();
    checks++;
    if (got.size() - g0 !== 1) begin errors++; $display("FAIL rstmid_pops got %0d exp 1", got.size() - g0); end
  endtask
  task automatic test_full_push_pop();
    int g0 = got.size(), o0 = ov_n;
    for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1, -1);
    send_frame(8'hA4, 1, 19 * H + 2);
    idle(2);
    checks += 4;
    if (count !== 4) begin errors++; $display("FAIL pp_count got %0d exp 4", count); end
    if (ov_n - o0 !== 0) begin errors++; $display("FAIL pp_overrun got %0d exp 0", ov_n - o0); end
    if (got.size() - g0 !== 1) begin errors++; $display("FAIL pp_pops got %0d exp 1", got.size() - g0); end
    if (rdata !== 8'hA1) begin errors++; $display("FAIL pp_head got %h exp a1", rdata); end
    drain();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[g0+i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL pp_byte%0d got %h exp %h", i, got[g0+i], 8'hA0 + 8'(i)); end
    end
  endtask
  task automatic test_random();
    logic [7:0] exp [$];
    logic [7:0] b;
    bit bad;
    int g0 = got.size(), f0 = fe_n, o0 = ov_n, ef = 0;
    rr_rand = 1;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(255, 0));
      bad = $urandom_range(5, 0) == 0;
      send_frame(b, !bad, -1);
      if (bad) begin
        ef++;
        rxd = 1;
        idle(3 * H);
      end else exp.push_back(b);
      idle($urandom_range(2 * H, 0));
    end
    idle(4 * H);
    rr_rand = 0;
    drain();
    checks += 3;
    if (got.size() - g0 !== exp.size()) begin errors++; $display("FAIL rnd_bytes got %0d exp %0d", got.size() - g0, exp.size()); end
    if (fe_n - f0 !== ef) begin errors++; $display("FAIL rnd_frame_err got %0d exp %0d", fe_n - f0, ef); end
    if (ov_n - o0 !== 0) begin errors++; $display("FAIL rnd_overrun got %0d exp 0", ov_n - o0); end
    foreach (exp[i]) begin
      checks++;
      if (got[g0+i] !== exp[i]) begin errors++; $display("FAIL rnd_byte%0d got %h exp %h", i, got[g0+i], exp[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_break();
    test_glitch();
    test_reset_mid();
    test_full_push_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
